// File: rtl/itlb_refill_ctrl.sv
// ITLB refill controller: takes one miss at a time, walks it through the PTW,
// picks a victim entry and writes the returned PTE into the entry array.
module itlb_refill_ctrl #(
    parameter int unsigned ENTRY_NUM = 32,
    parameter int unsigned MXLEN     = 64,
    parameter int unsigned VPN_W     = 27
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 miss_valid_i,
    input  logic [VPN_W-1:0]     miss_vpn_i,
    output logic                 miss_ready_o,
    output logic                 ptw_req_valid_o,
    output logic [VPN_W-1:0]     ptw_req_vpn_o,
    input  logic                 ptw_req_ready_i,
    input  logic                 ptw_resp_valid_i,
    input  logic [MXLEN-1:0]     ptw_resp_pte_i,
    input  logic                 ptw_resp_fault_i,
    input  logic [ENTRY_NUM-1:0] valid_vec_i,
    output logic [ENTRY_NUM-1:0] wr_en_o,
    output logic [MXLEN-1:0]     pte_wr_o,
    output logic [VPN_W-1:0]     tag_wr_vpn_o,
    output logic                 refill_done_o,
    output logic                 refill_fault_o,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [VPN_W-1:0]     r_vpn;
    logic [MXLEN-1:0]     r_pte;
    logic [IDX_W-1:0]     r_victim;
    logic                 r_victim_rr;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic                 r_flush_seen;
    logic                 r_fault;

    logic                 w_miss_ready;
    logic                 w_capture_resp;
    logic                 w_fault_nxt;
    logic                 w_write_fire;
    logic                 w_free_found;
    logic [IDX_W-1:0]     w_free_idx;
    logic [ENTRY_NUM-1:0] w_victim_onehot;

    // Lowest-index invalid entry, if any.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--) begin
            if (!valid_vec_i[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_miss_ready   = 1'b0;
        w_capture_resp = 1'b0;
        w_fault_nxt    = 1'b0;
        w_write_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_miss_ready = ~flush_i;
                if (miss_valid_i && !flush_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (ptw_req_ready_i) begin
                    w_state_nxt = (flush_i || r_flush_seen) ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    // A response arriving with the flush is dropped; nothing left to drain.
                    w_state_nxt = ptw_resp_valid_i ? S_IDLE : S_DRAIN;
                end else if (ptw_resp_valid_i) begin
                    if (ptw_resp_fault_i) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_capture_resp = 1'b1;
                        w_state_nxt    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_write_fire = ~flush_i;
                w_state_nxt  = S_IDLE;
            end
            S_DRAIN: begin
                if (ptw_resp_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Captured request, response, victim and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vpn        <= '0;
            r_pte        <= '0;
            r_victim     <= '0;
            r_victim_rr  <= 1'b0;
            r_rr_ptr     <= '0;
            r_flush_seen <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_fault <= w_fault_nxt;
            if (r_state == S_IDLE && miss_valid_i && w_miss_ready) begin
                r_vpn <= miss_vpn_i;
            end
            // Remember a flush that lands while the request is still stalled.
            if (r_state == S_REQ && !ptw_req_ready_i) begin
                r_flush_seen <= r_flush_seen | flush_i;
            end else begin
                r_flush_seen <= 1'b0;
            end
            if (w_capture_resp) begin
                r_pte       <= ptw_resp_pte_i;
                r_victim    <= w_free_found ? w_free_idx : r_rr_ptr;
                r_victim_rr <= ~w_free_found;
            end
            if (w_write_fire && r_victim_rr) begin
                r_rr_ptr <= (r_rr_ptr == IDX_W'(ENTRY_NUM - 1)) ? '0 : r_rr_ptr + IDX_W'(1);
            end
        end
    end

    assign w_victim_onehot = ENTRY_NUM'(1) << r_victim;

    // Outputs decode from state; reset forces every output low.
    assign miss_ready_o    = ~rst_i & w_miss_ready;
    assign ptw_req_valid_o = ~rst_i & (r_state == S_REQ);
    assign ptw_req_vpn_o   = ptw_req_valid_o ? r_vpn : '0;
    assign wr_en_o         = (~rst_i & w_write_fire) ? w_victim_onehot : '0;
    assign pte_wr_o        = (~rst_i & w_write_fire) ? r_pte : '0;
    assign tag_wr_vpn_o    = (~rst_i & w_write_fire) ? r_vpn : '0;
    assign refill_done_o   = ~rst_i & w_write_fire;
    assign refill_fault_o  = ~rst_i & r_fault;
    assign busy_o          = ~rst_i & (r_state != S_IDLE);

endmodule
